// File: rtl/reg_file.sv
// reg_file: 8-entry register file with two read ports, one write port,
// write-to-read bypass, per-register "written since reset" flags and a
// combinational debug read port.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   reg_sel_r0, reg_sel_r1   read port addresses
//   reg_sel_w0, reg_w0_rw    write port address and write enable
//   w0_data                  write data
//   r0_data, r1_data         read data (registered if READ_REG, else combinational)
//   dbg_sel, dbg_data        debug read address and data (combinational, no bypass)
//   written                  bit i set once register i has been written since reset
module reg_file #(
  parameter int unsigned DATA_W   = 16,
  parameter bit          ZERO_R0  = 1'b1,
  parameter bit          READ_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        reg_sel_r0,
  input  logic [2:0]        reg_sel_r1,
  input  logic [2:0]        reg_sel_w0,
  input  logic              reg_w0_rw,
  input  logic [DATA_W-1:0] w0_data,
  output logic [DATA_W-1:0] r0_data,
  output logic [DATA_W-1:0] r1_data,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [7:0]        written
);

  localparam int unsigned NUM_REGS = 8;

  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [NUM_REGS-1:0] written_q;
  logic                write_en_c;
  logic [DATA_W-1:0]   r0_next_c;
  logic [DATA_W-1:0]   r1_next_c;

  // A write to register 0 is dropped when it is hardwired to zero; reset
  // also suppresses the write so no bypass can leak through while in reset.
  assign write_en_c = reg_w0_rw && !rst && !(ZERO_R0 && (reg_sel_w0 == 3'd0));

  // Storage and written flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
      written_q <= '0;
    end else if (write_en_c) begin
      mem[reg_sel_w0]       <= w0_data;
      written_q[reg_sel_w0] <= 1'b1;
    end
  end

  // Read value as it stands after this edge's write; zero register overrides bypass
  always_comb begin
    r0_next_c = mem[reg_sel_r0];
    r1_next_c = mem[reg_sel_r1];
    if (write_en_c && (reg_sel_w0 == reg_sel_r0)) r0_next_c = w0_data;
    if (write_en_c && (reg_sel_w0 == reg_sel_r1)) r1_next_c = w0_data;
    if (ZERO_R0 && (reg_sel_r0 == 3'd0)) r0_next_c = '0;
    if (ZERO_R0 && (reg_sel_r1 == 3'd0)) r1_next_c = '0;
  end

  generate
    if (READ_REG) begin : g_read_reg
      logic [DATA_W-1:0] r0_q;
      logic [DATA_W-1:0] r1_q;

      // One-cycle read latency
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r0_q <= '0;
          r1_q <= '0;
        end else begin
          r0_q <= r0_next_c;
          r1_q <= r1_next_c;
        end
      end

      assign r0_data = r0_q;
      assign r1_data = r1_q;
    end else begin : g_read_comb
      assign r0_data = r0_next_c;
      assign r1_data = r1_next_c;
    end
  endgenerate

  assign dbg_data = mem[dbg_sel];
  assign written  = written_q;

endmodule

// File: tb/tb_reg_file.sv
`timescale 1ns/1ps
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [2:0]  reg_sel_r0, reg_sel_r1, reg_sel_w0, dbg_sel;
  logic        reg_w0_rw;
  logic [15:0] w0_data;

  // a: ZERO_R0=1 READ_REG=1, b: ZERO_R0=0 READ_REG=1, c: ZERO_R0=1 READ_REG=0
  logic [15:0] a_r0, a_r1, a_dbg, b_r0, b_r1, b_dbg, c_r0, c_r1, c_dbg;
  logic [7:0]  a_wr, b_wr, c_wr;

  reg_file #(.DATA_W(16), .ZERO_R0(1'b1), .READ_REG(1'b1)) dut_a (
    .clk(clk), .rst(rst), .reg_sel_r0(reg_sel_r0), .reg_sel_r1(reg_sel_r1),
    .reg_sel_w0(reg_sel_w0), .reg_w0_rw(reg_w0_rw), .w0_data(w0_data),
    .r0_data(a_r0), .r1_data(a_r1), .dbg_sel(dbg_sel), .dbg_data(a_dbg), .written(a_wr));

  reg_file #(.DATA_W(16), .ZERO_R0(1'b0), .READ_REG(1'b1)) dut_b (
    .clk(clk), .rst(rst), .reg_sel_r0(reg_sel_r0), .reg_sel_r1(reg_sel_r1),
    .reg_sel_w0(reg_sel_w0), .reg_w0_rw(reg_w0_rw), .w0_data(w0_data),
    .r0_data(b_r0), .r1_data(b_r1), .dbg_sel(dbg_sel), .dbg_data(b_dbg), .written(b_wr));

  reg_file #(.DATA_W(16), .ZERO_R0(1'b1), .READ_REG(1'b0)) dut_c (
    .clk(clk), .rst(rst), .reg_sel_r0(reg_sel_r0), .reg_sel_r1(reg_sel_r1),
    .reg_sel_w0(reg_sel_w0), .reg_w0_rw(reg_w0_rw), .w0_data(w0_data),
    .r0_data(c_r0), .r1_data(c_r1), .dbg_sel(dbg_sel), .dbg_data(c_dbg), .written(c_wr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: zero-register flavour (z1) and plain flavour (z0)
  logic [15:0] m1 [8];
  logic [15:0] m0 [8];
  logic [7:0]  w1, w0;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m1[i] = 16'h0;
      m0[i] = 16'h0;
    end
    w1 = 8'h00;
    w0 = 8'h00;
  endtask

  function automatic logic [15:0] exp_z1(input logic [2:0] s);
    return (s == 3'd0) ? 16'h0 : m1[s];
  endfunction

  // Combinational-read expectation before the edge (same-cycle bypass)
  function automatic logic [15:0] exp_comb(input logic [2:0] s);
    if (s == 3'd0) return 16'h0;
    if (reg_w0_rw && !rst && reg_sel_w0 == s) return w0_data;
    return m1[s];
  endfunction

  task automatic drive(input logic we, input logic [2:0] w, input logic [15:0] d,
                       input logic [2:0] s0, input logic [2:0] s1);
    reg_w0_rw  = we;
    reg_sel_w0 = w;
    w0_data    = d;
    reg_sel_r0 = s0;
    reg_sel_r1 = s1;
  endtask

  // Advance one edge and apply the same write to the model, then settle
  task automatic clock_edge();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (reg_w0_rw) begin
      if (reg_sel_w0 != 3'd0) begin
        m1[reg_sel_w0] = w0_data;
        w1[reg_sel_w0] = 1'b1;
      end
      m0[reg_sel_w0] = w0_data;
      w0[reg_sel_w0] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    dbg_sel = 3'd0;
    model_reset();
    #2;
    checks++;
    if (a_r0 !== 16'h0 || a_r1 !== 16'h0 || b_r0 !== 16'h0 || c_r0 !== 16'h0) begin
      errors++;
      $display("FAIL reset_rdata: a=%h/%h b=%h c=%h required 0", a_r0, a_r1, b_r0, c_r0);
    end
    checks++;
    if (a_wr !== 8'h00 || b_wr !== 8'h00) begin
      errors++;
      $display("FAIL reset_written: a=%h b=%h required 00", a_wr, b_wr);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    drive(1'b1, 3'd5, 16'h1234, 3'd0, 3'd0);
    clock_edge();
    drive(1'b0, 3'd0, 16'h0, 3'd5, 3'd0);
    clock_edge();
    checks++;
    if (a_r0 !== 16'h1234 || b_r0 !== 16'h1234) begin
      errors++;
      $display("FAIL basic_read: a=%h b=%h required 1234", a_r0, b_r0);
    end
    checks++;
    if (a_wr !== 8'h20) begin
      errors++;
      $display("FAIL basic_written: got %h required 20", a_wr);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 3'd2, 16'h0001, 3'd0, 3'd0);
    clock_edge();
    drive(1'b1, 3'd2, 16'hA5A5, 3'd2, 3'd2);
    #1;
    checks++;
    if (c_r0 !== 16'hA5A5 || c_r1 !== 16'hA5A5) begin
      errors++;
      $display("FAIL bypass_comb: got %h/%h required a5a5", c_r0, c_r1);
    end
    clock_edge();
    checks++;
    if (a_r0 !== 16'hA5A5 || a_r1 !== 16'hA5A5) begin
      errors++;
      $display("FAIL bypass_reg: got %h/%h required a5a5", a_r0, a_r1);
    end
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0);
    #1;
    checks++;
    if (c_r0 !== 16'h0 || c_r1 !== 16'h0) begin
      errors++;
      $display("FAIL zero_comb: got %h/%h required 0", c_r0, c_r1);
    end
    clock_edge();
    checks++;
    if (a_r0 !== 16'h0 || a_r1 !== 16'h0 || a_wr[0] !== 1'b0) begin
      errors++;
      $display("FAIL zero_r0_on: got %h/%h wr0=%b required 0/0 wr0=0", a_r0, a_r1, a_wr[0]);
    end
    checks++;
    if (b_r0 !== 16'hFFFF || b_r1 !== 16'hFFFF || b_wr[0] !== 1'b1) begin
      errors++;
      $display("FAIL zero_r0_off: got %h/%h wr0=%b required ffff/ffff wr0=1", b_r0, b_r1, b_wr[0]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 3'(i), 16'(i) * 16'h1111, 3'(i - 1), 3'(i));
      clock_edge();
      checks++;
      if (a_r0 !== exp_z1(3'(i - 1)) || a_r1 !== 16'(i) * 16'h1111) begin
        errors++;
        $display("FAIL b2b_read[%0d]: got %h/%h required %h/%h", i, a_r0, a_r1,
                 exp_z1(3'(i - 1)), 16'(i) * 16'h1111);
      end
    end
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    for (int i = 1; i < 8; i++) begin
      dbg_sel = 3'(i);
      #0.5;
      checks++;
      if (a_dbg !== 16'(i) * 16'h1111 || c_dbg !== m1[i]) begin
        errors++;
        $display("FAIL b2b_dbg[%0d]: got %h/%h required %h", i, a_dbg, c_dbg, 16'(i) * 16'h1111);
      end
    end
    checks++;
    if (a_wr !== 8'hFE || c_wr !== w1) begin
      errors++;
      $display("FAIL b2b_written: got %h/%h required fe", a_wr, c_wr);
    end
  endtask

  task automatic test_no_write();
    drive(1'b0, 3'd4, 16'hDEAD, 3'd4, 3'd4);
    dbg_sel = 3'd4;
    clock_edge();
    checks++;
    if (a_dbg !== 16'h4444 || a_r0 !== 16'h4444 || b_dbg !== m0[4]) begin
      errors++;
      $display("FAIL no_write_data: got %h/%h required 4444", a_dbg, a_r0);
    end
    checks++;
    if (a_wr !== w1 || b_wr !== w0) begin
      errors++;
      $display("FAIL no_write_flags: got %h/%h required %h/%h", a_wr, b_wr, w1, w0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      dbg_sel = 3'($urandom_range(0, 7));
      #1;
      checks++;
      if (c_r0 !== exp_comb(reg_sel_r0) || c_r1 !== exp_comb(reg_sel_r1)) begin
        errors++;
        $display("FAIL rand_comb[%0d]: got %h/%h required %h/%h", n, c_r0, c_r1,
                 exp_comb(reg_sel_r0), exp_comb(reg_sel_r1));
      end
      clock_edge();
      checks++;
      if (a_r0 !== exp_z1(reg_sel_r0) || a_r1 !== exp_z1(reg_sel_r1) ||
          b_r0 !== m0[reg_sel_r0] || b_r1 !== m0[reg_sel_r1]) begin
        errors++;
        $display("FAIL rand_reg[%0d]: a=%h/%h b=%h/%h required %h/%h %h/%h", n, a_r0, a_r1,
                 b_r0, b_r1, exp_z1(reg_sel_r0), exp_z1(reg_sel_r1), m0[reg_sel_r0], m0[reg_sel_r1]);
      end
      checks++;
      if (a_dbg !== m1[dbg_sel] || b_dbg !== m0[dbg_sel] || a_wr !== w1 || b_wr !== w0) begin
        errors++;
        $display("FAIL rand_dbg[%0d]: dbg=%h/%h wr=%h/%h required %h/%h %h/%h", n, a_dbg, b_dbg,
                 a_wr, b_wr, m1[dbg_sel], m0[dbg_sel], w1, w0);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3);
    clock_edge();
    checks++;
    if (a_r0 !== 16'hBEEF) begin
      errors++;
      $display("FAIL mid_pre: got %h required beef", a_r0);
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (a_r0 !== 16'h0 || a_r1 !== 16'h0 || b_r0 !== 16'h0 || c_r0 !== 16'h0 || c_r1 !== 16'h0) begin
      errors++;
      $display("FAIL mid_rdata: a=%h/%h b=%h c=%h/%h required 0", a_r0, a_r1, b_r0, c_r0, c_r1);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #0.5;
      checks++;
      if (a_dbg !== 16'h0 || b_dbg !== 16'h0) begin
        errors++;
        $display("FAIL mid_dbg[%0d]: got %h/%h required 0", i, a_dbg, b_dbg);
      end
    end
    checks++;
    if (a_wr !== 8'h00 || b_wr !== 8'h00) begin
      errors++;
      $display("FAIL mid_written: got %h/%h required 00", a_wr, b_wr);
    end
    dbg_sel = 3'd3;
    clock_edge();
    checks++;
    if (a_dbg !== 16'h0 || a_r0 !== 16'h0 || a_wr !== 8'h00) begin
      errors++;
      $display("FAIL mid_write_lost: dbg=%h r0=%h wr=%h required 0", a_dbg, a_r0, a_wr);
    end
    rst = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    clock_edge();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_zero_reg();
    test_back_to_back();
    test_no_write();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
